sparse_circulant_mult: RTL and testbench

Parametrised multiply of a streamed block vector by a sparse quasi-cyclic binary matrix, as used in the LDPC encoder datapath. Each output row is the XOR of left-rotated copies of selected input beats. Rotation amounts and the sparsity pattern come from a parameter table, so one block serves any row count. Ping-pong accumulator banks allow input and output to stream concurrently with valid/ready on both sides.

---
 rtl/sparse_circulant_mult.sv | 189 ++++++++++++++++++
 tb/tb_sparse_circulant_mult.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_circulant_mult.sv
// Streamed block vector times a sparse quasi-cyclic binary matrix (LDPC encoder path).
// One row slice per output word; ping-pong banks let block fill and drain overlap.

module sparse_circulant_row #(
    parameter int WIDTH = 96,
    parameter int IN_BEATS = 11,
    parameter logic [IN_BEATS*8-1:0] TAPS = '1
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [WIDTH-1:0]              i_data,
    input  logic [$clog2(IN_BEATS)-1:0]   i_beat,
    input  logic                          i_wr_en,
    input  logic                          i_wr_bank,
    output logic [1:0][WIDTH-1:0]         o_acc
);
    logic [IN_BEATS-1:0][WIDTH-1:0] term;

    // Rotations are constant per beat, so each is pure wiring; the beat count selects one.
    for (genvar b = 0; b < IN_BEATS; b++) begin : g_beat
        localparam int S = int'(TAPS[b*8 +: 8]);
        if (S == 255) begin : g_none
            assign term[b] = '0;
        end else if (S >= WIDTH) begin : g_bad
            $error("TAP_SHIFTS field %0d not below WIDTH %0d", S, WIDTH);
            assign term[b] = '0;
        end else if (S == 0) begin : g_pass
            assign term[b] = i_data;
        end else begin : g_rot
            assign term[b] = {i_data[WIDTH-1-S:0], i_data[WIDTH-1:WIDTH-S]};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            o_acc <= '0;
        else if (i_wr_en)
            o_acc[i_wr_bank] <= (i_beat == '0) ? term[i_beat] : (o_acc[i_wr_bank] ^ term[i_beat]);
    end
endmodule

module sparse_circulant_mult #(
    parameter int WIDTH = 96,
    parameter int IN_BEATS = 11,
    parameter int OUT_ROWS = 2,
    parameter logic [OUT_ROWS*IN_BEATS*8-1:0] TAP_SHIFTS = '1
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [WIDTH-1:0]          i_input_data,
    input  logic                      i_input_valid,
    output logic                      o_input_ready,
    output logic [WIDTH-1:0]          o_output_data,
    output logic                      o_output_valid,
    output logic [$clog2(OUT_ROWS):0] o_output_row,
    output logic                      o_output_last,
    input  logic                      i_output_ready
);
    localparam int BW = $clog2(IN_BEATS);
    localparam int RW = $clog2(OUT_ROWS) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(IN_BEATS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(OUT_ROWS - 1);

    if (WIDTH < 2 || WIDTH > 255) begin : g_bad_width
        $error("WIDTH %0d outside 2..255", WIDTH);
    end
    if (IN_BEATS < 2 || OUT_ROWS < 1 || OUT_ROWS > IN_BEATS) begin : g_bad_shape
        $error("need IN_BEATS >= 2 and 1 <= OUT_ROWS <= IN_BEATS");
    end

    typedef enum logic [1:0] {FILL_PING, FILL_PONG, FWAIT_PING, FWAIT_PONG} fill_state_t;
    typedef enum logic [1:0] {RWAIT_PING, READ_PING, RWAIT_PONG, READ_PONG} rd_state_t;

    fill_state_t fill_state;
    rd_state_t   rd_state;
    logic [BW-1:0] beat;
    logic [1:0]    full;
    logic [(1<<RW)-1:0][1:0][WIDTH-1:0] acc_all;

    logic          fill_bank, rd_bank, accept, fill_done, out_acc, rd_done;
    logic [1:0]    set_full, clr_full;
    logic [RW-1:0] row_nxt;

    assign fill_bank = (fill_state == FILL_PONG);
    assign rd_bank   = (rd_state == READ_PONG);
    assign accept    = i_input_valid & o_input_ready;
    assign fill_done = accept && (beat == LAST_BEAT);
    assign out_acc   = o_output_valid & i_output_ready;
    assign rd_done   = out_acc && (o_output_row == LAST_ROW);
    assign set_full  = fill_done ? (fill_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_full  = rd_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign row_nxt   = o_output_row + 1'b1;

    // Rows past OUT_ROWS are padding so the row counter indexes the array exactly.
    for (genvar r = 0; r < (1 << RW); r++) begin : g_row
        if (r < OUT_ROWS) begin : g_used
            sparse_circulant_row #(
                .WIDTH(WIDTH), .IN_BEATS(IN_BEATS),
                .TAPS(TAP_SHIFTS[r*IN_BEATS*8 +: IN_BEATS*8])
            ) u_row (
                .i_clock(i_clock), .i_reset_n(i_reset_n), .i_data(i_input_data),
                .i_beat(beat), .i_wr_en(accept), .i_wr_bank(fill_bank),
                .o_acc(acc_all[r])
            );
        end else begin : g_pad
            assign acc_all[r] = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) full <= '0;
        else            full <= (full | set_full) & ~clr_full;
    end

    // Ready is registered alongside the state, so it only ever reflects FILL_* states.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill_state    <= FILL_PING;
            o_input_ready <= 1'b0;
            beat          <= '0;
        end else begin
            if (accept) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            case (fill_state)
                FILL_PING, FILL_PONG: begin
                    o_input_ready <= 1'b1;
                    if (fill_done) begin
                        if (full[~fill_bank]) begin
                            fill_state    <= fill_bank ? FWAIT_PING : FWAIT_PONG;
                            o_input_ready <= 1'b0;
                        end else begin
                            fill_state    <= fill_bank ? FILL_PING : FILL_PONG;
                        end
                    end
                end
                FWAIT_PING: if (!full[0]) begin
                    fill_state    <= FILL_PING;
                    o_input_ready <= 1'b1;
                end
                FWAIT_PONG: if (!full[1]) begin
                    fill_state    <= FILL_PONG;
                    o_input_ready <= 1'b1;
                end
                default: fill_state <= FILL_PING;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_state       <= RWAIT_PING;
            o_output_valid <= 1'b0;
            o_output_data  <= '0;
            o_output_row   <= '0;
            o_output_last  <= 1'b0;
        end else begin
            case (rd_state)
                RWAIT_PING, RWAIT_PONG: begin
                    if (full[rd_state == RWAIT_PONG]) begin
                        rd_state       <= (rd_state == RWAIT_PONG) ? READ_PONG : READ_PING;
                        o_output_valid <= 1'b1;
                        o_output_data  <= acc_all[0][rd_state == RWAIT_PONG];
                        o_output_row   <= '0;
                        o_output_last  <= (OUT_ROWS == 1);
                    end
                end
                READ_PING, READ_PONG: if (out_acc) begin
                    if (o_output_row == LAST_ROW) begin
                        o_output_row <= '0;
                        if (full[~rd_bank]) begin
                            rd_state      <= rd_bank ? READ_PING : READ_PONG;
                            o_output_data <= acc_all[0][~rd_bank];
                            o_output_last <= (OUT_ROWS == 1);
                        end else begin
                            rd_state       <= rd_bank ? RWAIT_PING : RWAIT_PONG;
                            o_output_valid <= 1'b0;
                            o_output_data  <= '0;
                            o_output_last  <= 1'b0;
                        end
                    end else begin
                        o_output_row  <= row_nxt;
                        o_output_data <= acc_all[row_nxt][rd_bank];
                        o_output_last <= (row_nxt == LAST_ROW);
                    end
                end
                default: rd_state <= RWAIT_PING;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_circulant_mult.sv
// Scoreboard bench for sparse_circulant_mult: bit-loop rotate model, queue of expected words.

module tb_sparse_circulant_mult;
    localparam int W = 96;
    localparam int NB = 11;
    localparam int NR = 2;

    typedef logic [W-1:0] blk_t [NB];
    typedef struct packed { logic [W-1:0] data; logic [1:0] row; logic last; } exp_t;

    function automatic int get_tap(input int r, input int b);
        if (r == 0) begin
            case (b) 0: return 42; 5: return 67; 7: return 40; 10: return 25; default: return -1; endcase
        end
        case (b) 1: return 0; 10: return 95; default: return -1; endcase
    endfunction

    function automatic logic [NR*NB*8-1:0] mk_taps();
        logic [NR*NB*8-1:0] t;
        t = '1;
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < NB; b++)
                if (get_tap(r, b) >= 0) t[(r*NB+b)*8 +: 8] = 8'(get_tap(r, b));
        return t;
    endfunction

    localparam logic [NR*NB*8-1:0] TAPS = mk_taps();

    logic         i_clock, i_reset_n, i_input_valid, o_input_ready;
    logic [W-1:0] i_input_data, o_output_data;
    logic         o_output_valid, o_output_last, i_output_ready;
    logic [1:0]   o_output_row;

    sparse_circulant_mult #(.WIDTH(W), .IN_BEATS(NB), .OUT_ROWS(NR), .TAP_SHIFTS(TAPS)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_input_data(i_input_data), .i_input_valid(i_input_valid), .o_input_ready(o_input_ready),
        .o_output_data(o_output_data), .o_output_valid(o_output_valid), .o_output_row(o_output_row),
        .o_output_last(o_output_last), .i_output_ready(i_output_ready)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int   n_chk = 0, n_pass = 0, stall_cnt = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int s);
        logic [W-1:0] y;
        y = '0;
        for (int i = 0; i < W; i++) y[(i + s) % W] = x[i];
        return y;
    endfunction

    task automatic push_exp(input blk_t d);
        for (int r = 0; r < NR; r++) begin
            exp_t e;
            e.data = '0;
            for (int b = 0; b < NB; b++)
                if (get_tap(r, b) >= 0) e.data = e.data ^ rotl(d[b], get_tap(r, b));
            e.row  = 2'(r);
            e.last = (r == NR - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat is taken.
    task automatic put_beat(input logic [W-1:0] d);
        int n;
        n = 0;
        i_input_valid = 1'b1;
        i_input_data  = d;
        @(negedge i_clock);
        while (!o_input_ready && n < 2000) begin
            n++;
            @(negedge i_clock);
        end
        if (n >= 2000) chk("in_timeout", 96'(n), 96'(0));
        stall_cnt += n;
        @(posedge i_clock); #1;
        i_input_valid = 1'b0;
    endtask

    task automatic send_block(input blk_t d, input int gap_pct);
        for (int b = 0; b < NB; b++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct)
                repeat ($urandom_range(3, 1)) begin @(posedge i_clock); #1; end
            put_beat(d[b]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge i_clock);
            n++;
        end
        @(posedge i_clock); #1;
        chk("drain", 96'(exp_q.size()), 96'(0));
    endtask

    function automatic blk_t zero_blk();
        blk_t d;
        for (int b = 0; b < NB; b++) d[b] = '0;
        return d;
    endfunction

    function automatic blk_t rand_blk();
        blk_t d;
        for (int b = 0; b < NB; b++) d[b] = {$urandom, $urandom, $urandom};
        return d;
    endfunction

    // Monitor: a word is consumed at the next posedge when valid&ready at the negedge.
    initial forever begin
        @(negedge i_clock);
        if (i_reset_n && o_output_valid && i_output_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 96'(1), 96'(0));
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", o_output_data, e.data);
                chk("out_row", 96'(o_output_row), 96'(e.row));
                chk("out_last", 96'(o_output_last), 96'(e.last));
            end
        end
    end

    initial begin
        blk_t d;
        int   zeros;
        i_reset_n = 1'b0; i_input_valid = 1'b0; i_input_data = '0; i_output_ready = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_valid", 96'(o_output_valid), 96'(0));
        chk("rst_data", o_output_data, 96'(0));
        chk("rst_row", 96'(o_output_row), 96'(0));
        chk("rst_last", 96'(o_output_last), 96'(0));
        chk("rst_in_rdy", 96'(o_input_ready), 96'(0));
        @(negedge i_clock); i_reset_n = 1'b1;
        @(posedge i_clock); #1;
        chk("rdy_after_rst", 96'(o_input_ready), 96'(1));

        // 1: single tap on beat 0, plus first-word latency
        d = zero_blk(); d[0] = 96'h1;
        push_exp(d);
        send_block(d, 0);
        chk("lat_pre", 96'(o_output_valid), 96'(0));
        @(posedge i_clock); #1;
        chk("lat_valid", 96'(o_output_valid), 96'(1));
        chk("lat_data", o_output_data, 96'h1 << 42);
        drain();

        // 2: pass-through tap and wrap-around tap
        d = zero_blk(); d[1] = 96'hA5; d[10] = 96'h1;
        push_exp(d);
        send_block(d, 0);
        drain();

        // 3: untapped beat contributes nothing, accumulators restart
        d = zero_blk(); d[3] = '1;
        push_exp(d);
        send_block(d, 0);
        drain();

        // 4: backpressure fills both banks then resumes
        i_output_ready = 1'b0;
        d = rand_blk(); push_exp(d); send_block(d, 0);
        d = rand_blk(); push_exp(d); send_block(d, 0);
        chk("bp_rdy_drop", 96'(o_input_ready), 96'(0));
        repeat (3) begin
            @(negedge i_clock);
            chk("bp_hold_valid", 96'(o_output_valid), 96'(1));
            chk("bp_hold_data", o_output_data, exp_q[0].data);
        end
        @(posedge i_clock); #1;
        i_output_ready = 1'b1;
        zeros = 0;
        @(negedge i_clock);
        while (!o_input_ready && zeros < 50) begin
            zeros++;
            @(negedge i_clock);
        end
        chk("bp_resume", 96'(zeros), 96'(3));
        @(posedge i_clock); #1;
        d = rand_blk(); push_exp(d); send_block(d, 0);
        drain();

        // 5: random blocks with random gaps, output always ready
        stall_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            d = rand_blk(); push_exp(d); send_block(d, 30);
        end
        drain();
        chk("no_stall", 96'(stall_cnt), 96'(0));

        // 6: reset mid-block while block 1 is held at the output
        i_output_ready = 1'b0;
        d = rand_blk(); push_exp(d); send_block(d, 0);
        for (int b = 0; b < 6; b++) put_beat({$urandom, $urandom, $urandom});
        chk("pre_rst_valid", 96'(o_output_valid), 96'(1));
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 96'(o_output_valid), 96'(0));
        chk("mid_rst_data", o_output_data, 96'(0));
        chk("mid_rst_row", 96'(o_output_row), 96'(0));
        chk("mid_rst_last", 96'(o_output_last), 96'(0));
        chk("mid_rst_in_rdy", 96'(o_input_ready), 96'(0));
        exp_q.delete();
        @(negedge i_clock); i_reset_n = 1'b1; i_output_ready = 1'b1;
        @(posedge i_clock); #1;
        chk("rdy_after_rst2", 96'(o_input_ready), 96'(1));
        d = zero_blk(); d[5] = 96'hDEAD_BEEF; d[1] = 96'h1234;
        push_exp(d);
        send_block(d, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
